// File: rtl/fifo_ctrl_pkg.sv
// Shared parameters and read-sequencer state encoding for the FIFO access controller.
package fifo_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_ISSUE   = 2'd1,
        R_CAPTURE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, the last-winner pointer is registered.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    // last = 1 means requester 1 won most recently, so requester 0 wins a tie
    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (elig == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (grant[0]) begin
            last <= 1'b0;
        end else if (grant[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one FIFO between two write producers and one read consumer; tracks occupancy
// and drives the FIFO strobes from registers.
import fifo_ctrl_pkg::*;

module fifo_access_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ack,
    input  logic              c_req,
    output logic              c_valid,
    output logic [DATA_W-1:0] c_data,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output rd_state_t         rd_state
);

    // Handshakes: a requester holds req (and its data) until it sees a one-cycle
    // ack/c_valid pulse; a req still high while ack is high is not a new request.
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             wr_allow;
    logic             rd_issue;
    logic             capture;
    logic [CNT_W-1:0] count_next;
    rd_state_t        state_q;
    rd_state_t        state_d;

    assign elig     = {p1_req & ~p1_ack, p0_req & ~p0_ack};
    assign wr_allow = (count != CNT_W'(DEPTH));
    assign rd_state = state_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (wr_allow),
        .elig   (elig),
        .grant  (grant)
    );

    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        capture  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (c_req && !c_valid && (count != '0)) begin
                    rd_issue = 1'b1;
                    state_d  = R_ISSUE;
                end
            end
            R_ISSUE: begin
                state_d = R_CAPTURE;
            end
            R_CAPTURE: begin
                capture = 1'b1;
                state_d = R_IDLE;
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Both blocking conditions look at the current count, so this never wraps.
    assign count_next = count + CNT_W'(grant[0] | grant[1]) - CNT_W'(rd_issue);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
            fifo_rd  <= 1'b0;
            c_valid  <= 1'b0;
            c_data   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            p0_ack  <= grant[0];
            p1_ack  <= grant[1];
            fifo_wr <= grant[0] | grant[1];
            if (grant[0]) begin
                fifo_din <= p0_data;
            end else if (grant[1]) begin
                fifo_din <= p1_data;
            end
            fifo_rd <= rd_issue;
            c_valid <= capture;
            if (capture) begin
                c_data <= fifo_dout;
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: doc/fifo_access_ctrl.md
# fifo_access_ctrl

Controller that shares the 16-entry, 8-bit FIFO between two write producers and one read consumer. It round-robin arbitrates producer writes and sequences consumer reads through a three-state read FSM. It tracks occupancy itself and blocks writes when full and reads when empty. It sits directly in front of the FIFO and drives the FIFO's write/read strobes and write data.

## Interface
- DATA_W, 8, data width
- DEPTH, 16, FIFO entries
- CNT_W, 5, occupancy counter width (holds 0..DEPTH)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  producer write request, held until ack
- p0_data / p1_data  in  DATA_W  producer write data, stable while req high
- p0_ack / p1_ack  out  1  one-cycle write-accepted pulse
- c_req  in  1  consumer read request, held until c_valid
- c_valid  out  1  one-cycle read-data-valid pulse
- c_data  out  DATA_W  read data, held until next c_valid
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  DATA_W  FIFO write data
- fifo_rd  out  1  FIFO read strobe
- fifo_dout  in  DATA_W  FIFO read data, registered on the edge sampling fifo_rd
- count  out  CNT_W  occupancy
- full / empty  out  1  count==DEPTH / count==0

## Operation
- All outputs are registered.
- Reset values: acks 0, c_valid 0, c_data 0, fifo_wr 0, fifo_din 0, fifo_rd 0, count 0, empty 1, full 0, read FSM R_IDLE. Round-robin pointer: last grant = p1, so p0 wins first.
- Write arbitration, evaluated every edge:
  - A producer is eligible when its req is 1 and its ack is currently 0. This masks the cycle after an ack, so there is no double write.
  - If count<DEPTH and any producer is eligible, grant one. If both are eligible, grant the one not granted last.
  - On grant: fifo_wr=1, fifo_din=winner data, winner ack=1 for one cycle, pointer updated. Otherwise fifo_wr=0 and no ack.
- Read FSM:
  - R_IDLE: if c_req=1, c_valid=0 and count>0, then fifo_rd=1 and go to R_ISSUE.
  - R_ISSUE: fifo_rd=0, go to R_CAPTURE.
  - R_CAPTURE: c_data=fifo_dout, c_valid=1, go to R_IDLE.
- count_next = count + grant - rd_issue.
  - Full and empty checks use the current count only.
  - A write is blocked at count==DEPTH even if a read issues on the same edge.
  - A read is blocked at count==0 even if a write is granted on the same edge.
  - A simultaneous write and read leaves count unchanged.
- count never exceeds DEPTH and never underflows. No wrap-around is exposed.
- Reset mid-operation: every register returns to its reset value immediately, any pending ack or c_valid is lost, and the FIFO must be reset by the same rst.

## Timing
- Write latency: req sampled at edge E, ack and fifo_wr high during cycle E..E+1, and the FIFO stores the data at E+1.
- Aggregate write throughput: 1 per cycle when both producers alternate. A single producer gets at most 1 write per 2 cycles.
- Read latency: c_req sampled at E, fifo_rd high during E..E+1, fifo_dout valid after E+1, c_valid high during E+2..E+3.
- Read throughput: at most 1 per 4 cycles, because R_IDLE is masked while c_valid=1.
- Write and read paths are independent and may be active on the same cycle.

## Structure
- Package fifo_ctrl_pkg holds:
  - DATA_W, DEPTH, CNT_W
  - the read FSM enum (R_IDLE, R_ISSUE, R_CAPTURE, encoded as 2 bits)
- Sub-module rr_arb2: 2-requester round-robin arbiter with eligibility inputs, grant one-hot output and pointer register. It has its own clk and rst.
- The top level holds the occupancy counter, read FSM and output registers.

## Test plan
- Reset, then p0_req=1 with data 0xA5 held until ack: p0_ack pulses once, fifo_wr one cycle, fifo_din=0xA5, count=1, empty=0.
- p0 and p1 both requesting continuously with 0x11 and 0x22: grants alternate p0,p1,p0,…, one write per cycle, count reaches 16, full=1, and no fifo_wr occurs while full.
- Fill with 16 writes, then hold c_req: 16 c_valid pulses, 4 cycles apart, with data in write order. count reaches 0, empty=1, and no further fifo_rd.
- count=16, write request and read complete together: the write is blocked on the issue edge and accepted one edge later, count returns to 16.
- count=0, c_req and p1_req (0x3C) rise together: fifo_rd is withheld on the first edge, the write is granted, the read issues next edge, c_valid returns 0x3C.
- Assert rst during R_ISSUE with count=5: outputs return to reset values asynchronously, count=0, FSM=R_IDLE, and no c_valid after rst deasserts.
